// File: rtl/wave_display_pkg.sv
// wave_display_pkg: freeze FSM states, default parameters and channel-width helper
package wave_display_pkg;
  typedef enum logic [1:0] {LIVE, PEND_FRZ, FROZEN, PEND_LIVE} frz_state_e;
  localparam int N_CH_DEF       = 2;
  localparam int SAMPLE_W_DEF   = 8;
  localparam int COL_BITS_DEF   = 8;
  localparam int XSHIFT_DEF     = 1;
  localparam int X_START_DEF    = 256;
  localparam int BAND_SHIFT_DEF = 7;
  function automatic int ch_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wave_freeze_ctrl.sv
// wave_freeze_ctrl: frame-synchronous hold of the displayed RAM half
module wave_freeze_ctrl
  import wave_display_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_start_i,
  input  logic hold_i,
  input  logic read_index_i,
  output logic disp_index_o,
  output logic frozen_o
);
  frz_state_e state_q, state_d;
  logic held_q, held_d;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= LIVE;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    case (state_q)
      LIVE:      state_d = hold_i ? PEND_FRZ : LIVE;
      PEND_FRZ: begin
        state_d = !hold_i ? LIVE : frame_start_i ? FROZEN : PEND_FRZ;
        held_d  = (hold_i && frame_start_i) ? read_index_i : held_q;
      end
      FROZEN:    state_d = hold_i ? FROZEN : PEND_LIVE;
      PEND_LIVE: state_d = hold_i ? FROZEN : frame_start_i ? LIVE : PEND_LIVE;
      default:   state_d = LIVE;
    endcase
  end
  assign frozen_o     = (state_q == FROZEN) || (state_q == PEND_LIVE);
  assign disp_index_o = frozen_o ? held_q : read_index_i;
endmodule

// File: rtl/wave_display_multi.sv
// wave_display_multi: multi-channel stacked-band waveform renderer, 2-cycle pixel latency.
// Optional WAVE_DISPLAY_GRID_EN adds valid_grid_o (band separators and dashed midline).
module wave_display_multi
  import wave_display_pkg::*;
#(
  parameter  int N_CH       = N_CH_DEF,
  parameter  int SAMPLE_W   = SAMPLE_W_DEF,
  parameter  int COL_BITS   = COL_BITS_DEF,
  parameter  int XSHIFT     = XSHIFT_DEF,
  parameter  int X_START    = X_START_DEF,
  parameter  int BAND_SHIFT = BAND_SHIFT_DEF,
  localparam int CH_BITS    = ch_bits(N_CH),
  localparam int AW         = CH_BITS + 1 + COL_BITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic [10:0]         x_i,
  input  logic [9:0]          y_i,
  input  logic                read_index_i,
  input  logic                hold_i,
  input  logic [SAMPLE_W-1:0] read_value_i,
  output logic [AW-1:0]       read_address_o,
  output logic                valid_pixel_o,
  output logic [CH_BITS-1:0]  pixel_ch_o,
  output logic                frozen_o
`ifdef WAVE_DISPLAY_GRID_EN
  ,
  output logic                valid_grid_o
`endif
);
  localparam int WIN_W = (1 << COL_BITS) << XSHIFT;
  localparam logic [11:0] X_LO = 12'(X_START);
  localparam logic [11:0] X_HI = 12'(X_START + WIN_W);
  localparam logic [10:0] Y_HI = 11'(N_CH << BAND_SHIFT);
  logic in_win, in_band, frame_start, disp_index, hit;
  logic [10:0] x_off;
  logic [COL_BITS-1:0] col;
  logic [CH_BITS-1:0] ch, ch_q;
  logic valid_q, in_win_q, in_band_q, first_q;
  logic [BAND_SHIFT-1:0] r_q, s, p;
  logic [AW-1:0] last_addr_q;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  assign in_win         = ({1'b0, x_i} >= X_LO) && ({1'b0, x_i} < X_HI);
  assign in_band        = {1'b0, y_i} < Y_HI;
  assign x_off          = x_i - X_LO[10:0];
  assign col            = COL_BITS'(x_off >> XSHIFT);
  assign ch             = y_i[BAND_SHIFT +: CH_BITS];
  assign frame_start    = valid_i && (x_i == '0) && (y_i == '0);
  assign read_address_o = (in_win && in_band) ? {ch, disp_index, col} : '0;
  wave_freeze_ctrl u_frz (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .frame_start_i (frame_start),
    .hold_i        (hold_i),
    .read_index_i  (read_index_i),
    .disp_index_o  (disp_index),
    .frozen_o      (frozen_o)
  );
  // read_value_i belongs to last_addr_q; capture it as prev once the address moves on
  assign prev_d = (read_address_o != last_addr_q) ? read_value_i : prev_q;
  assign s      = BAND_SHIFT'(read_value_i >> (SAMPLE_W - BAND_SHIFT));
  assign p      = first_q ? s : BAND_SHIFT'(prev_q >> (SAMPLE_W - BAND_SHIFT));
  assign hit    = ((p <= r_q) && (r_q <= s)) || ((s <= r_q) && (r_q <= p));
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      valid_q       <= 1'b0;
      in_win_q      <= 1'b0;
      in_band_q     <= 1'b0;
      first_q       <= 1'b0;
      ch_q          <= '0;
      r_q           <= '0;
      last_addr_q   <= '0;
      prev_q        <= '0;
      valid_pixel_o <= 1'b0;
      pixel_ch_o    <= '0;
    end else begin
      valid_q       <= valid_i;
      in_win_q      <= in_win;
      in_band_q     <= in_band;
      first_q       <= col == '0;
      ch_q          <= ch;
      r_q           <= y_i[BAND_SHIFT-1:0];
      last_addr_q   <= read_address_o;
      prev_q        <= prev_d;
      valid_pixel_o <= valid_q && in_win_q && in_band_q && hit;
      pixel_ch_o    <= ch_q;
    end
`ifdef WAVE_DISPLAY_GRID_EN
  localparam logic [BAND_SHIFT-1:0] HALF = BAND_SHIFT'(1 << (BAND_SHIFT - 1));
  logic x2_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      x2_q         <= 1'b0;
      valid_grid_o <= 1'b0;
    end else begin
      x2_q         <= x_i[2];
      valid_grid_o <= valid_q && in_win_q && in_band_q && ((r_q == '0) || ((r_q == HALF) && !x2_q));
    end
`endif
endmodule

// File: tb/tb_wave_display_multi.sv
// tb_wave_display_multi: directed and randomized checks against a behavioural renderer model
module tb_wave_display_multi;
  logic clk = 1'b0;
  logic reset, valid, hold, read_index;
  logic [10:0] x;
  logic [9:0] y;
  logic [7:0] read_value;
  logic [9:0] read_address;
  logic valid_pixel, frozen;
  logic [0:0] pixel_ch;
`ifdef WAVE_DISPLAY_GRID_EN
  logic valid_grid;
`endif
  always #5 clk = ~clk;
  wave_display_multi dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .valid_i        (valid),
    .x_i            (x),
    .y_i            (y),
    .read_index_i   (read_index),
    .hold_i         (hold),
    .read_value_i   (read_value),
    .read_address_o (read_address),
    .valid_pixel_o  (valid_pixel),
    .pixel_ch_o     (pixel_ch),
    .frozen_o       (frozen)
`ifdef WAVE_DISPLAY_GRID_EN
    ,
    .valid_grid_o   (valid_grid)
`endif
  );
  logic [7:0] mem [1024];
  int total = 0, passed = 0;
  logic [9:0] m_cur_a, ram_addr;
  logic [7:0] m_prev;
  logic m_frozen, m_held, m_hprev;
  logic e_vp, e_ch, e_grid, have_prev;
  logic [10:0] x_prev;
  logic obs [2048];
  logic obs_g [2048];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, want);
  endtask
  task automatic model_reset;
    m_cur_a = '0; ram_addr = '0; m_prev = '0;
    m_frozen = 1'b0; m_held = 1'b0; m_hprev = 1'b0;
    e_vp = 1'b0; e_ch = 1'b0; e_grid = 1'b0; have_prev = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1; valid = 1'b0; x = '0; y = '0; hold = 1'b0; read_index = 1'b0; read_value = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  // one pixel clock: drive, check address, advance model, check outputs of the previous pixel
  task automatic cycle(input logic v, input int xi, input int yi);
    logic [9:0] ea;
    logic iw, ib, ch, di, fs, h, nvp, ngrid;
    logic [7:0] c;
    int r, s, p;
    read_value = mem[ram_addr];
    valid = v; x = 11'(xi); y = 10'(yi);
    #1;
    iw = (xi >= 256) && (xi < 768);
    ib = yi < 256;
    c  = iw ? 8'((xi - 256) / 2) : 8'd0;
    ch = ((yi / 128) % 2) == 1;
    di = m_frozen ? m_held : read_index;
    ea = (iw && ib) ? {ch, di, c} : 10'd0;
    chk("read_address", read_address, ea);
    if (ea != m_cur_a) begin
      m_prev  = mem[m_cur_a];
      m_cur_a = ea;
    end
    s = mem[ea] / 2;
    p = (c == 0) ? s : m_prev / 2;
    r = yi % 128;
    h = ((p <= r) && (r <= s)) || ((s <= r) && (r <= p));
    nvp   = v && iw && ib && h;
    ngrid = v && iw && ib && ((r == 0) || ((r == 64) && (((xi / 4) % 2) == 0)));
    ram_addr = read_address;
    fs = v && (xi == 0) && (yi == 0);
    @(posedge clk);
    if (!m_frozen && m_hprev && hold && fs) begin
      m_frozen = 1'b1;
      m_held   = read_index;
    end else if (m_frozen && !m_hprev && !hold && fs) m_frozen = 1'b0;
    m_hprev = hold;
    @(negedge clk);
    chk("valid_pixel", valid_pixel, e_vp);
    chk("pixel_ch", pixel_ch, e_ch);
    chk("frozen", frozen, m_frozen);
`ifdef WAVE_DISPLAY_GRID_EN
    chk("valid_grid", valid_grid, e_grid);
    if (have_prev) obs_g[x_prev] = valid_grid;
`endif
    if (have_prev) obs[x_prev] = valid_pixel;
    e_vp = nvp; e_ch = ch; e_grid = ngrid; x_prev = 11'(xi); have_prev = 1'b1;
  endtask
  task automatic scan(input int x0, input int x1, input int yi);
    for (int i = x0; i <= x1; i++) cycle(1'b1, i, yi);
    cycle(1'b0, 0, 0);
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 512; i++) mem[i] = 8'h40;
    mem[512] = 8'd0; mem[513] = 8'd20; mem[768] = 8'd0; mem[769] = 8'd20;
    do_reset();
    chk("rst_valid_pixel", valid_pixel, 0);
    chk("rst_pixel_ch", pixel_ch, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_addr", read_address, 0);
    scan(256, 767, 32);
    cnt = 0;
    for (int i = 256; i < 768; i++) cnt += int'(obs[i]);
    chk("flat_y32_hits", cnt, 512);
    scan(256, 767, 33);
    cnt = 0;
    for (int i = 256; i < 768; i++) cnt += int'(obs[i]);
    chk("flat_y33_hits", cnt, 0);
    scan(256, 259, 133);
    chk("ramp_x256", obs[256], 0);
    chk("ramp_x257", obs[257], 0);
    chk("ramp_x258", obs[258], 1);
    chk("ramp_x259", obs[259], 1);
    cycle(1'b1, 255, 32);
    chk("edge_addr_x255", read_address, 0);
    cycle(1'b1, 768, 32);
    chk("edge_addr_x768", read_address, 0);
    cycle(1'b1, 300, 256);
    chk("edge_addr_y256", read_address, 0);
    cycle(1'b0, 0, 0);
    chk("edge_pix_x255", obs[255], 0);
    chk("edge_pix_x768", obs[768], 0);
    chk("edge_pix_y256", obs[300], 0);
    read_index = 1'b1; hold = 1'b1;
    repeat (3) cycle(1'b1, 100, 50);
    chk("frz_pending", frozen, 0);
    cycle(1'b1, 0, 0);
    chk("frz_on", frozen, 1);
    read_index = 1'b0;
    cycle(1'b1, 300, 10);
    chk("frz_held_bit", read_address[8], 1);
    hold = 1'b0;
    repeat (2) cycle(1'b1, 300, 10);
    chk("frz_pend_live", frozen, 1);
    cycle(1'b1, 0, 0);
    chk("frz_off", frozen, 0);
    cycle(1'b1, 300, 10);
    chk("live_bit", read_address[8], 0);
    hold = 1'b1; read_index = 1'b1;
    cycle(1'b1, 5, 5);
    cycle(1'b1, 0, 0);
    read_index = 1'b0;
    for (int i = 256; i < 270; i++) cycle(1'b1, i, 32);
    chk("pre_reset_vp", valid_pixel, 1);
    chk("pre_reset_frozen", frozen, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_vp", valid_pixel, 0);
    chk("async_rst_frozen", frozen, 0);
    chk("async_rst_live_bit", read_address[8], 0);
    @(negedge clk);
    reset = 1'b0; hold = 1'b0;
    model_reset();
`ifdef WAVE_DISPLAY_GRID_EN
    scan(256, 256, 64);
    chk("grid_y64_x256", obs_g[256], 1);
    scan(260, 260, 64);
    chk("grid_y64_x260", obs_g[260], 0);
    scan(256, 256, 128);
    chk("grid_y128_x256", obs_g[256], 1);
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int l = 0; l < 40; l++) begin
      int yl, xs, len;
      yl = $urandom_range(0, 300);
      xs = $urandom_range(230, 740);
      len = $urandom_range(20, 80);
      read_index = 1'($urandom);
      if ($urandom_range(0, 3) == 0) hold = ~hold;
      if ($urandom_range(0, 1) == 0) cycle(1'b1, 0, 0);
      for (int i = 0; i < len; i++) cycle(1'($urandom_range(0, 9) != 0), xs + i, yl);
      cycle(1'b0, 0, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wave_display_multi.md
Name: wave_display_multi

Overview:
- Next-generation waveform renderer for the VGA pixel pipeline.
- Draws N_CH audio sample channels as stacked horizontal bands, each with its own sample RAM bank, behind a single shared synchronous-read RAM port.
- Adds a frame-synchronous freeze (hold) controller that pins the displayed RAM half at a frame boundary.
- Sits between the pixel-coordinate generator and the colour mixer; emits valid_pixel plus the channel index for per-channel colouring.

Parameters:
- N_CH, 2, number of channels/bands (1, 2 or 4); CH_BITS = max(1, clog2(N_CH)).
- SAMPLE_W, 8, sample width in bits.
- COL_BITS, 8, log2 of samples per line (256).
- XSHIFT, 1, log2 of pixels per sample (2).
- X_START, 256, first x of the drawing window; window width = 2^COL_BITS << XSHIFT.
- BAND_SHIFT, 7, log2 of band height in rows (128); requires SAMPLE_W >= BAND_SHIFT.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  x/y are inside the active display area.
- x  in  11  pixel column.
- y  in  10  pixel row.
- read_index  in  1  live RAM half currently safe to display.
- hold  in  1  level request: freeze the display while high.
- read_value  in  SAMPLE_W  RAM data; valid one cycle after read_address.
- read_address  out  CH_BITS+1+COL_BITS  {ch, disp_index, col}.
- valid_pixel  out  1  pixel belongs to a waveform trace.
- pixel_ch  out  CH_BITS  channel of the current valid_pixel.
- frozen  out  1  display index is held.

Behaviour:
- Stage 0, combinational:
  - in_win = X_START <= x < X_START + window width.
  - col = (x - X_START) >> XSHIFT.
  - ch = y[BAND_SHIFT +: CH_BITS].
  - in_band = y < (N_CH << BAND_SHIFT).
  - read_address = {ch, disp_index, col} when in_win && in_band, otherwise 0.
- Stage 1, registered: valid, in_win, in_band, ch, band row r = y[BAND_SHIFT-1:0], first-column flag, and last_addr.
- Sample hold register prev:
  - Loads read_value when last_addr changes.
  - On the first sample column of a line, the comparison uses prev := read_value, so no segment joins line ends.
- Row compare:
  - s = read_value >> (SAMPLE_W - BAND_SHIFT); p = prev scaled the same way.
  - hit = (p <= r <= s) || (s <= r <= p), with both orderings inclusive.
- Stage 2, registered:
  - valid_pixel = valid_d && in_win_d && in_band_d && hit.
  - pixel_ch = ch_d.
  - Latency from x/y to valid_pixel is exactly 2 cycles. Callers delay colour to match.
- Freeze FSM, advancing only at frame start (valid && x==0 && y==0):
  - LIVE → PEND_FRZ when hold=1.
  - PEND_FRZ → FROZEN at frame start, latching held_index := read_index.
  - PEND_FRZ → LIVE if hold drops before frame start.
  - FROZEN → PEND_LIVE when hold=0.
  - PEND_LIVE → LIVE at frame start.
  - PEND_LIVE → FROZEN if hold rises again.
  - disp_index = held_index in FROZEN/PEND_LIVE, otherwise read_index.
  - frozen = 1 in FROZEN/PEND_LIVE.
- Reset (asynchronous, any cycle, including mid-frame):
  - valid_pixel=0, pixel_ch=0, frozen=0, FSM=LIVE, prev=0, last_addr=0, all pipeline regs 0.
  - The first frame after reset may show one spurious first column; this is accepted.
- Boundaries:
  - x outside the window or y below the last band: address 0, no pixel.
  - Within one line, all pixels come from the same channel; the channel changes only at band rows.

Optional Feature:
- Macro WAVE_DISPLAY_GRID_EN.
- When defined:
  - Adds a grid output valid_grid (1 bit, same 2-cycle latency).
  - Asserted on band separator rows (r==0) and on the dashed band midline (r == 2^(BAND_SHIFT-1) && x[2]==0), both only inside the window.
- When undefined: the port and logic are absent, and trace behaviour is identical.

Decomposition:
- Package wave_display_pkg holds:
  - Freeze FSM state enum (LIVE, PEND_FRZ, FROZEN, PEND_LIVE).
  - Default parameter constants.
  - A clog2-style helper for CH_BITS.
- Sub-module wave_freeze_ctrl contains the FSM, held_index and frozen. Its inputs are clk, reset, frame_start, hold and read_index; its outputs are disp_index and frozen.

Test Plan:
- Flat line: RAM ch0 all 0x40, scan x=256..767 at y=32 (r=32, s=0x40>>1=32) → valid_pixel=1 two cycles after each x, pixel_ch=0; at y=33 → 0.
- Ramp: ch1 col0=0, col1=20 (scaled 0, 10), y=128+5 → pixel asserted at x=258/259, not at x=256/257 (first column self-compare).
- Window edges: x=255 and x=768 → read_address=0, valid_pixel=0; y=256 (beyond 2 bands) → no pixel.
- Freeze: hold=1 mid-frame with read_index=1 → frozen stays 0 until the next frame start, then 1; read_index toggled to 0 → address bit keeps 1. hold=0 → returns to live at the following frame start.
- Async reset asserted mid-line while valid_pixel=1 → valid_pixel and frozen drop immediately, FSM=LIVE.
- With WAVE_DISPLAY_GRID_EN: y=64, x=256 → valid_grid=1; x=260 (x[2]=1) → 0; y=128 → 1.
